pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Controller that sequences a serial pattern-matching datapath over fixed-length frames. It accepts a pattern through a valid/ready configuration handshake and arms a scan on `start`. It shifts qualified serial bits through a PAT_W-bit window and counts every (overlapping) match. At the end of the frame it reports match count, first-match position and a one-cycle `done`. It sits between the serial receive front end and the status/CSR logic that consumes detection results.

## Interface
- `PAT_W`, 5: pattern and window width in bits.
- `FRAME_LEN`, 32: bits scanned per frame (must be ≥ PAT_W).
- `CNT_W`, $clog2(FRAME_LEN+1): width of counters and position outputs.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  pattern offered.
- `cfg_pattern`  in  PAT_W  pattern value.
- `cfg_ready`  out  1  pattern can be accepted (high only in IDLE).
- `start`  in  1  arm scan of one frame.
- `bit_valid`  in  1  `serial_in` qualified this cycle.
- `serial_in`  in  1  serial data bit.
- `busy`  out  1  high in SCAN.
- `done`  out  1  one-cycle pulse at end of frame.
- `match_pulse`  out  1  one-cycle pulse per match.
- `found`  out  1  at least one match in last/current frame.
- `match_count`  out  CNT_W  matches in last/current frame.
- `first_pos`  out  CNT_W  0-based bit index completing the first match (0 if none).

## Operation
- States: IDLE, SCAN, DONE.
- Reset: state IDLE; stored pattern 0, `loaded` flag 0, window 0, fill count 0, bit index 0. All outputs 0 except `cfg_ready`=1.
- IDLE:
  - `cfg_valid & cfg_ready` latches `cfg_pattern` and sets `loaded`.
  - `start & loaded` goes to SCAN. On that transition it clears window, fill count, bit index, `match_count`, `first_pos` and `found`.
  - `start` without `loaded` is ignored.
  - If `cfg_valid` and `start` occur in the same cycle, the new pattern is latched and the scan uses it only if `loaded` was already set. The scan always uses the newly latched pattern.
- SCAN:
  - Each cycle with `bit_valid`=1 accepts one bit: `window[PAT_W-1]` ← `serial_in`, and `window[i]` ← `window[i+1]`. The oldest bit sits in `window[0]`.
  - Fill count increments and saturates at PAT_W. Bit index increments.
  - A match is the post-shift window equal to the pattern with post-shift fill count = PAT_W. Reset-zero window contents never match.
  - On a match: `match_pulse`=1, `match_count`+1, `found`=1. On the first match, `first_pos` takes the index of the accepted bit.
  - Overlapping matches all count. `match_count` max is FRAME_LEN−PAT_W+1, so no overflow.
  - `cfg_*` and `start` are ignored; `cfg_ready`=0.
  - After the FRAME_LEN-th accepted bit, the state goes to DONE.
- DONE: lasts one cycle with `done`=1, then returns to IDLE. `match_count`, `first_pos` and `found` hold until the next accepted `start`.
- Reset mid-SCAN: same as power-on reset. Results and the stored pattern are cleared, and no `done` pulse is produced.

## Timing
- All outputs are registered.
- `match_pulse`, `match_count`, `found` and `first_pos` update in the cycle after the edge that accepts the completing bit.
- `start` sampled at edge E: `busy`=1 from cycle E+1. The first bit can be accepted at edge E+1.
- With `bit_valid` held high, the last bit is accepted at edge E+FRAME_LEN. In the following cycle `done`=1, `busy`=0, and any final `match_pulse` is 1. The next cycle is IDLE with `cfg_ready`=1.
- `bit_valid` gaps stall the scan with no state change. There is no timeout.
- Configuration latency: pattern usable from the cycle after the handshake.

## Structure
- Package `pattern_scan_pkg`:
  - state enum typedef (IDLE/SCAN/DONE);
  - default PAT_W and FRAME_LEN localparams.
- Sub-module `shift_window`: PAT_W shift register with shift-enable and clear, plus saturating fill counter and a `full` output. The controller FSM, counters and compare logic stay in `pattern_scan_ctrl`.

## Test plan
- Reset -> all outputs 0, `cfg_ready`=1. `start` with nothing loaded -> `busy` stays 0.
- Load 5'b10110, start, stream 0,1,1,0,1 then 27 zeros -> one `match_pulse`, `match_count`=1, `first_pos`=4, `found`=1, `done` pulses once after bit 31.
- Load 5'b11111, stream 7 ones then 25 zeros -> matches at bits 4, 5, 6, `match_count`=3, `first_pos`=4.
- Load 5'b00000, stream 32 zeros -> no match before bit 4, `match_count`=28, `first_pos`=4.
- `bit_valid` toggling 1/0 during the scan, plus `cfg_valid` with 5'b11111 mid-SCAN -> `cfg_ready`=0, pattern unchanged, `done` 1 cycle after the 32nd accepted bit.
- Pattern 5'b10110, reset asserted after 10 bits -> IDLE, `match_count`=0, `found`=0, no `done`. A subsequent `start` is ignored until a pattern is reloaded.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// Shared types and default geometry for the serial pattern scanner.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    localparam int unsigned DefPatW     = 5;
    localparam int unsigned DefFrameLen = 32;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Configuration, serial-data and result signals of the pattern scanner.
interface pattern_scan_ctrl_if import pattern_scan_pkg::*; #(
    parameter int unsigned PAT_W = DefPatW,
    parameter int unsigned CNT_W = $clog2(DefFrameLen + 1)
);
    logic             cfg_valid;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_ready;
    logic             start;
    logic             bit_valid;
    logic             serial_in;
    logic             busy;
    logic             done;
    logic             match_pulse;
    logic             found;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] first_pos;

    modport master (
        output cfg_valid, cfg_pattern, start, bit_valid, serial_in,
        input  cfg_ready, busy, done, match_pulse, found, match_count, first_pos
    );

    modport slave (
        input  cfg_valid, cfg_pattern, start, bit_valid, serial_in,
        output cfg_ready, busy, done, match_pulse, found, match_count, first_pos
    );

endinterface

// File: rtl/shift_window.sv
// PAT_W-bit serial window with saturating fill counter; outputs show the
// window and fill state as they will be once the offered bit is shifted in.
module shift_window import pattern_scan_pkg::*; #(
    parameter int unsigned PAT_W = DefPatW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic             clear_i,
    input  logic             bit_i,
    output logic [PAT_W-1:0] window_o,
    output logic             full_o
);
    localparam int unsigned FillW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] window_q, window_d;
    logic [FillW-1:0] fill_q;
    logic             full_d;

    // The oldest bit falls off on every shift and is never read back.
    logic unused_oldest;
    assign unused_oldest = window_q[0];

    always_comb begin
        window_d = {bit_i, window_q[PAT_W-1:1]};
        full_d   = (fill_q >= FillW'(PAT_W - 1));
    end

    assign window_o = window_d;
    assign full_o   = full_d;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (shift_en_i) begin
            window_q <= window_d;
            if (fill_q != FillW'(PAT_W)) begin
                fill_q <= fill_q + FillW'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame-based serial pattern scanner: counts overlapping matches and reports
// the first match position with a one-cycle done pulse at end of frame.
module pattern_scan_ctrl import pattern_scan_pkg::*; #(
    parameter int unsigned PAT_W     = DefPatW,
    parameter int unsigned FRAME_LEN = DefFrameLen,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input logic                clk,
    input logic                reset,
    pattern_scan_ctrl_if.slave bus
);
    state_e           state_q;
    logic [PAT_W-1:0] pattern_q;
    logic             loaded_q;
    logic [CNT_W-1:0] bit_idx_q;
    logic [CNT_W-1:0] match_count_q;
    logic [CNT_W-1:0] first_pos_q;
    logic             found_q;
    logic             match_pulse_q;
    logic             done_q;
    logic             busy_q;
    logic             cfg_ready_q;

    logic             accept_bit;
    logic             start_ok;
    logic             is_match;
    logic             last_bit;
    logic [PAT_W-1:0] win_post;
    logic             full_post;

    assign accept_bit = (state_q == StScan) && bus.bit_valid;
    assign start_ok   = (state_q == StIdle) && bus.start && loaded_q;
    assign is_match   = accept_bit && full_post && (win_post == pattern_q);
    assign last_bit   = accept_bit && (bit_idx_q == CNT_W'(FRAME_LEN - 1));

    shift_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (accept_bit),
        .clear_i    (start_ok),
        .bit_i      (bus.serial_in),
        .window_o   (win_post),
        .full_o     (full_post)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            pattern_q     <= '0;
            loaded_q      <= 1'b0;
            bit_idx_q     <= '0;
            match_count_q <= '0;
            first_pos_q   <= '0;
            found_q       <= 1'b0;
            match_pulse_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            cfg_ready_q   <= 1'b1;
        end else begin
            match_pulse_q <= is_match;
            done_q        <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A pattern offered alongside start is latched; the scan
                    // only launches if a pattern was already loaded.
                    if (bus.cfg_valid && cfg_ready_q) begin
                        pattern_q <= bus.cfg_pattern;
                        loaded_q  <= 1'b1;
                    end
                    if (start_ok) begin
                        state_q       <= StScan;
                        busy_q        <= 1'b1;
                        cfg_ready_q   <= 1'b0;
                        bit_idx_q     <= '0;
                        match_count_q <= '0;
                        first_pos_q   <= '0;
                        found_q       <= 1'b0;
                    end
                end
                StScan: begin
                    if (accept_bit) begin
                        bit_idx_q <= bit_idx_q + CNT_W'(1);
                        if (is_match) begin
                            match_count_q <= match_count_q + CNT_W'(1);
                            found_q       <= 1'b1;
                            if (!found_q) begin
                                first_pos_q <= bit_idx_q;
                            end
                        end
                        if (last_bit) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.match_pulse = match_pulse_q;
    assign bus.found       = found_q;
    assign bus.match_count = match_count_q;
    assign bus.first_pos   = first_pos_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl with a frame-level reference model.
module tb_pattern_scan_ctrl;
    localparam int unsigned PatW     = 5;
    localparam int unsigned FrameLen = 32;
    localparam int unsigned CntW     = 6;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pattern_scan_ctrl_if #(.PAT_W(PatW), .CNT_W(CntW)) bus ();

    pattern_scan_ctrl #(
        .PAT_W     (PatW),
        .FRAME_LEN (FrameLen),
        .CNT_W     (CntW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations collected by scan_frame, judged by each test.
    logic [31:0]     obs_mask;
    int              obs_spurious;
    int              obs_done_cnt;
    bit              obs_done_ok;
    int              obs_cfg_ready_hi;
    int              obs_busy_low;
    bit              obs_timeout;
    logic [CntW-1:0] obs_count;
    logic [CntW-1:0] obs_first;
    logic            obs_found;
    logic            obs_busy_at_done;
    logic            obs_after_ready;
    logic            obs_after_done;

    // Bit k set when the 5 bits ending at frame position k equal the pattern,
    // the newest bit being the pattern MSB.
    function automatic logic [31:0] model_mask(input logic [4:0] pat, input logic [31:0] bits);
        logic [31:0] m = '0;
        for (int k = PatW - 1; k < FrameLen; k++) begin
            if (bits[k -: 5] == pat) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic int first_of(input logic [31:0] m);
        for (int k = 0; k < 32; k++) begin
            if (m[k]) return k;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cfg_valid   = 1'b0;
        bus.cfg_pattern = '0;
        bus.start       = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.serial_in   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_pattern(input logic [4:0] pat);
        bus.cfg_valid   = 1'b1;
        bus.cfg_pattern = pat;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // mode 0: bit_valid always high, 1: alternating, 2: random gaps.
    task automatic scan_frame(input logic [31:0] bits, input int mode, input bit noise);
        int   acc = 0;
        int   cyc = 0;
        bit   fin = 0;
        logic bv;
        obs_mask = '0; obs_spurious = 0; obs_done_cnt = 0; obs_done_ok = 0;
        obs_cfg_ready_hi = 0; obs_busy_low = 0; obs_timeout = 0;
        while (!fin && cyc < 1000) begin
            case (mode)
                0:       bv = 1'b1;
                1:       bv = (cyc % 2 == 0);
                default: bv = ($urandom_range(0, 3) != 0);
            endcase
            if (acc >= FrameLen) bv = 1'b0;
            bus.bit_valid = bv;
            bus.serial_in = (acc < FrameLen) ? bits[acc] : 1'b0;
            if (noise) begin
                bus.cfg_valid   = 1'($urandom_range(0, 1));
                bus.cfg_pattern = 5'b11111;
                bus.start       = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
            if (bv) acc++;
            if (bus.match_pulse) begin
                if (bv) obs_mask[acc-1] = 1'b1;
                else    obs_spurious++;
            end
            if (bus.cfg_ready) obs_cfg_ready_hi++;
            if (bus.done) begin
                obs_done_cnt++;
                obs_done_ok      = bv && (acc == FrameLen);
                obs_count        = bus.match_count;
                obs_first        = bus.first_pos;
                obs_found        = bus.found;
                obs_busy_at_done = bus.busy;
                fin              = 1;
            end else if (!bus.busy) begin
                obs_busy_low++;
            end
        end
        idle_inputs();
        obs_timeout = !fin;
        tick();
        obs_after_ready = bus.cfg_ready;
        obs_after_done  = bus.done;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", bus.cfg_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0 || bus.match_pulse !== 1'b0 || bus.found !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got done=%b pulse=%b found=%b expected 0", bus.done, bus.match_pulse, bus.found); end
        checks++; if (bus.match_count !== '0 || bus.first_pos !== '0) begin
            errors++; $display("FAIL reset_counts: got count=%0d first=%0d expected 0", bus.match_count, bus.first_pos); end
        do_start();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_unloaded: got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_single_match();
        load_pattern(5'b10110);
        do_start();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        scan_frame(32'h0000_0016, 0, 0);
        checks++; if (obs_timeout || !obs_done_ok || obs_done_cnt != 1) begin
            errors++; $display("FAIL single_done: got timeout=%0d ok=%0d cnt=%0d expected 0 1 1", obs_timeout, obs_done_ok, obs_done_cnt); end
        checks++; if (obs_mask !== 32'h0000_0010 || obs_spurious != 0) begin
            errors++; $display("FAIL single_pulses: got %h/%0d expected 00000010/0", obs_mask, obs_spurious); end
        checks++; if (obs_count !== 6'd1 || obs_first !== 6'd4 || obs_found !== 1'b1) begin
            errors++; $display("FAIL single_result: got %0d/%0d/%b expected 1/4/1", obs_count, obs_first, obs_found); end
        checks++; if (obs_busy_at_done !== 1'b0 || obs_after_ready !== 1'b1 || obs_after_done !== 1'b0) begin
            errors++; $display("FAIL single_end: got busy=%b ready=%b done=%b expected 0 1 0", obs_busy_at_done, obs_after_ready, obs_after_done); end
        tick(); tick();
        checks++; if (bus.match_count !== 6'd1 || bus.first_pos !== 6'd4 || bus.found !== 1'b1) begin
            errors++; $display("FAIL single_hold: got %0d/%0d/%b expected 1/4/1", bus.match_count, bus.first_pos, bus.found); end
    endtask

    task automatic test_overlap_ones();
        load_pattern(5'b11111);
        do_start();
        scan_frame(32'h0000_007F, 0, 0);
        checks++; if (obs_mask !== 32'h0000_0070) begin errors++; $display("FAIL ones_pulses: got %h expected 00000070", obs_mask); end
        checks++; if (obs_count !== 6'd3 || obs_first !== 6'd4) begin
            errors++; $display("FAIL ones_result: got %0d/%0d expected 3/4", obs_count, obs_first); end
    endtask

    task automatic test_all_zero();
        load_pattern(5'b00000);
        do_start();
        scan_frame(32'h0000_0000, 0, 0);
        checks++; if (obs_mask !== 32'hFFFF_FFF0) begin errors++; $display("FAIL zero_pulses: got %h expected fffffff0", obs_mask); end
        checks++; if (obs_count !== 6'd28 || obs_first !== 6'd4 || !obs_done_ok) begin
            errors++; $display("FAIL zero_result: got %0d/%0d done_ok=%0d expected 28/4/1", obs_count, obs_first, obs_done_ok); end
    endtask

    task automatic test_gaps_cfg_noise();
        logic [31:0] bits;
        logic [31:0] exp;
        bits = $urandom;
        bits[12:8] = 5'b10110;
        exp = model_mask(5'b10110, bits);
        load_pattern(5'b10110);
        do_start();
        scan_frame(bits, 1, 1);
        checks++; if (obs_mask !== exp || obs_spurious != 0) begin
            errors++; $display("FAIL gaps_pulses: got %h/%0d expected %h/0", obs_mask, obs_spurious, exp); end
        checks++; if (obs_cfg_ready_hi != 0 || obs_busy_low != 0) begin
            errors++; $display("FAIL gaps_status: got ready_hi=%0d busy_low=%0d expected 0 0", obs_cfg_ready_hi, obs_busy_low); end
        checks++; if (obs_timeout || !obs_done_ok || obs_done_cnt != 1) begin
            errors++; $display("FAIL gaps_done: got timeout=%0d ok=%0d cnt=%0d expected 0 1 1", obs_timeout, obs_done_ok, obs_done_cnt); end
        checks++; if (obs_count !== 6'($countones(exp)) || obs_first !== 6'(first_of(exp))) begin
            errors++; $display("FAIL gaps_result: got %0d/%0d expected %0d/%0d", obs_count, obs_first, $countones(exp), first_of(exp)); end
        // Pattern must still be 10110 despite the 11111 offers during the scan.
        do_start();
        scan_frame(32'h0000_0016, 0, 0);
        checks++; if (obs_mask !== 32'h0000_0010) begin errors++; $display("FAIL gaps_pattern_kept: got %h expected 00000010", obs_mask); end
    endtask

    task automatic test_random_frames();
        logic [4:0]  pat;
        logic [31:0] bits;
        logic [31:0] exp;
        int          p;
        for (int n = 0; n < 6; n++) begin
            pat  = 5'($urandom);
            bits = $urandom;
            p    = $urandom_range(4, 31);
            bits[p -: 5] = pat;
            exp = model_mask(pat, bits);
            load_pattern(pat);
            do_start();
            scan_frame(bits, 2, 0);
            checks++; if (obs_timeout || !obs_done_ok || obs_mask !== exp || obs_spurious != 0) begin
                errors++; $display("FAIL rand_frame%0d: got mask=%h ok=%0d to=%0d expected %h 1 0", n, obs_mask, obs_done_ok, obs_timeout, exp); end
            checks++; if (obs_count !== 6'($countones(exp)) || obs_first !== 6'(first_of(exp)) || obs_found !== 1'b1) begin
                errors++; $display("FAIL rand_result%0d: got %0d/%0d/%b expected %0d/%0d/1", n, obs_count, obs_first, obs_found, $countones(exp), first_of(exp)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bits;
        logic [31:0] exp;
        bits = $urandom;
        bits[20:16] = 5'b11111;
        exp = model_mask(5'b11111, bits);
        load_pattern(5'b11111);
        do_start();
        scan_frame(32'h0000_007F, 0, 0);
        do_start();
        checks++; if (bus.busy !== 1'b1 || bus.match_count !== '0 || bus.found !== 1'b0) begin
            errors++; $display("FAIL b2b_restart: got busy=%b count=%0d found=%b expected 1 0 0", bus.busy, bus.match_count, bus.found); end
        scan_frame(bits, 0, 0);
        checks++; if (obs_mask !== exp || obs_count !== 6'($countones(exp))) begin
            errors++; $display("FAIL b2b_result: got %h/%0d expected %h/%0d", obs_mask, obs_count, exp, $countones(exp)); end
    endtask

    task automatic test_cfg_start_same_cycle();
        logic [31:0] exp;
        do_reset();
        bus.cfg_valid = 1'b1; bus.cfg_pattern = 5'b11111; bus.start = 1'b1;
        tick();
        idle_inputs();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL same_cycle_unloaded: got busy=%b expected 0", bus.busy); end
        bus.cfg_valid = 1'b1; bus.cfg_pattern = 5'b00000; bus.start = 1'b1;
        tick();
        idle_inputs();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL same_cycle_loaded: got busy=%b expected 1", bus.busy); end
        exp = model_mask(5'b00000, 32'h0000_007F);
        scan_frame(32'h0000_007F, 0, 0);
        checks++; if (obs_mask !== exp) begin errors++; $display("FAIL same_cycle_pattern: got %h expected %h", obs_mask, exp); end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] bits = 32'h0000_0016;
        int          done_seen = 0;
        load_pattern(5'b10110);
        do_start();
        for (int i = 0; i < 10; i++) begin
            bus.bit_valid = 1'b1;
            bus.serial_in = bits[i];
            tick();
        end
        checks++; if (bus.found !== 1'b1) begin errors++; $display("FAIL midreset_pre: got found=%b expected 1", bus.found); end
        bus.bit_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.bit_valid = 1'b0;
        checks++; if (bus.match_count !== '0 || bus.found !== 1'b0 || bus.first_pos !== '0) begin
            errors++; $display("FAIL midreset_results: got %0d/%b/%0d expected 0/0/0", bus.match_count, bus.found, bus.first_pos); end
        checks++; if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_state: got busy=%b ready=%b expected 0 1", bus.busy, bus.cfg_ready); end
        for (int i = 0; i < 4; i++) begin
            if (bus.done) done_seen++;
            tick();
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", done_seen); end
        do_start();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_start_ignored: got busy=%b expected 0", bus.busy); end
        load_pattern(5'b10110);
        do_start();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midreset_reload: got busy=%b expected 1", bus.busy); end
        scan_frame(bits, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_match();
        test_overlap_ones();
        test_all_zero();
        test_gaps_cfg_noise();
        test_random_frames();
        test_back_to_back();
        test_cfg_start_same_cycle();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
